bp_me_burst_arbiter: RTL
========================

// Module: bp_me_burst_arbiter
// PURPOSE
//  Shares one BP Burst client channel (header + data) among num_req_p BP Burst masters.
//  Typical masters are lite-to-burst converters (UCE, I/O, CFG) feeding one memory/DRAM port.
//  Round-robin arbitration on headers. The winner is locked until every data beat of its
//  message is forwarded, so header/data streams of different masters never interleave.
// PARAMETERS
//  bp_params_p     e_bp_default_cfg   proc config; supplies paddr/lce widths, cce_block_width_p
//  num_req_p       2                  number of burst masters, >=2
//  data_width_p    64                 burst data beat width (bits); divides cce_block_width_p
//  payload_mask_p  0                  bit i set => msg_type i carries data, e.g. (1<<e_mem_msg_wr)|(1<<e_mem_msg_uc_wr)
// PORTS
//  clk_i               in   1                single clock
//  reset_n_i           in   1                synchronous, active-low reset
//  mem_header_i        in   num_req_p*H      H = bp mem header width; master i at slice i
//  mem_header_v_i      in   num_req_p        per-master header valid
//  mem_header_ready_o  out  num_req_p        per-master header ready (ready-valid-and)
//  mem_data_i          in   num_req_p*data_width_p  per-master data beat
//  mem_data_v_i        in   num_req_p        per-master data valid
//  mem_data_ready_o    out  num_req_p        per-master data ready
//  mem_header_o        out  H                muxed header to client
//  mem_header_v_o      out  1                header valid
//  mem_header_ready_i  in   1                client header ready
//  mem_data_o          out  data_width_p     muxed data beat
//  mem_data_v_o        out  1                data valid
//  mem_data_ready_i    in   1                client data ready
//  grant_id_o          out  clog2(num_req_p) index of locked/selected master
//  busy_o              out  1                1 while in e_data
// BEHAVIOUR
//  Reset (reset_n_i=0 at posedge): state=e_idle, rr pointer=num_req_p-1 (master 0 highest
//  priority first), beat count=0. All *_v_o, *_ready_o, busy_o = 0 while reset is asserted.
//  e_idle: winner = first valid master after rr pointer, wrapping (combinational).
//   mem_header_o/v_o = winner's header/valid. Only the winner sees mem_header_ready_o = mem_header_ready_i.
//   All mem_data_ready_o = 0 and mem_data_v_o = 0.
//   Zero-latency: header passes through in the same cycle.
//   On header handshake: rr pointer <= winner; lock id <= winner.
//    If payload_mask_p[msg_type] = 1: state <= e_data, beats_left <= nbeats-1.
//    Otherwise remain in e_idle; the next arbitration happens next cycle.
//  nbeats = max(1, (1<<size) / (data_width_p/8)); clamp to cce_block_width_p/data_width_p.
//   Counter width clog2(max beats)+1, so no wrap.
//  e_data: all mem_header_ready_o = 0 and mem_header_v_o = 0.
//   mem_data_o/v_o = locked master's data/valid; its mem_data_ready_o = mem_data_ready_i.
//   On each data handshake, beats_left decrements. A handshake with beats_left==0 -> e_idle.
//   Data valid from non-locked masters is ignored (held off, not dropped).
//  Headers from other masters stall during e_data. Their valid persists and they win later in RR order.
//  Back-to-back: the last beat and the next header never transfer in the same cycle (1 cycle min gap).
//  grant_id_o = winner in e_idle, lock id in e_data.
//  Reset mid-burst: return to e_idle at once. No partial-message recovery; masters are reset together.
//  No combinational path from mem_*_ready_i to any *_v_o.
// STRUCTURE
//  State enum {e_idle, e_data} is local. payload_mask_p and the header struct come from bp_me_pkg
//  (declare_bp_mem_if). Add a shared bp_me_pkg function for burst beat count (size, beat bytes).
//  Use one sub-module: bsg_arb_round_robin (reset_i = ~reset_n_i, yumi on header handshake).
//  Mux the header and data vectors with bsg_mux_one_hot from the grant.
// TESTING
//  1. Single master 0, wr size 64B, data_width 64 -> 1 header then 8 beats on master 0 only; busy_o high 8 cycles.
//  2. Masters 0,1 both issue 8B rd (no payload) every cycle -> headers alternate 0,1,0,1; zero data beats.
//  3. Master 1 wr 32B locked while master 0 presents header -> master 0 header_ready=0 until beat 4 sent;
//     master 0 granted next cycle.
//  4. Client drops mem_data_ready_i randomly during a 64B burst -> all 8 beats in order, grant never switches.
//  5. Reset_n_i low in e_data after beat 3 -> next cycle all valids/readys 0, state e_idle,
//     first grant after reset = master 0.
//  6. 2B uncached write with data_width 64 -> nbeats=1: one header, one beat, then return to e_idle.

Source files
------------

// File: rtl/bp_me_burst_arbiter_pkg.sv
// Shared types and helpers for the BP memory-engine burst arbiter.
//
// Contents:
//   bp_mem_msg_e       memory message opcodes (bit position in payload masks)
//   bp_mem_msg_size_e  log2 of the message size in bytes
//   bp_mem_header_s    burst header carried on the header channel
//   burst_beats()      number of data beats a message of a given size occupies
package bp_me_burst_arbiter_pkg;

  localparam int paddr_width_gp = 40;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3,
    e_mem_msg_pre   = 4'd4
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1   = 3'd0,
    e_mem_msg_size_2   = 3'd1,
    e_mem_msg_size_4   = 3'd2,
    e_mem_msg_size_8   = 3'd3,
    e_mem_msg_size_16  = 3'd4,
    e_mem_msg_size_32  = 3'd5,
    e_mem_msg_size_64  = 3'd6,
    e_mem_msg_size_128 = 3'd7
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [7:0]                tag;
    logic [paddr_width_gp-1:0] addr;
    bp_mem_msg_size_e          size;
    bp_mem_msg_e               msg_type;
  } bp_mem_header_s;

  // Messages smaller than one beat still take a full beat, and nothing may
  // exceed one cache block worth of beats.
  function automatic int unsigned burst_beats(input logic [2:0]  size,
                                              input int unsigned beat_bytes,
                                              input int unsigned max_beats);
    int unsigned bytes;
    int unsigned beats;
    bytes = 32'd1 << size;
    beats = bytes / beat_bytes;
    if (beats == 0) beats = 1;
    if (beats > max_beats) beats = max_beats;
    return beats;
  endfunction

endpackage

// File: rtl/bp_me_burst_arbiter_rr.sv
// Round-robin arbiter used to pick the next burst master on the header channel.
//
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset (pointer returns to num_req_p-1)
//   reqs_i    per-requester request vector
//   yumi_i    current winner was consumed; advance the pointer to it
//   grants_o  one-hot grant of the current winner (all zero when no request)
//   tag_o     index of the current winner
//   v_o       at least one request is present
module bp_me_burst_arbiter_rr
  #(parameter int num_req_p = 2,
    localparam int id_width_lp = $clog2(num_req_p))
  (input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [num_req_p-1:0]   reqs_i,
   input  logic                   yumi_i,
   output logic [num_req_p-1:0]   grants_o,
   output logic [id_width_lp-1:0] tag_o,
   output logic                   v_o);

  logic [id_width_lp-1:0] ptr_q, ptr_d;
  logic [id_width_lp-1:0] winner;
  logic                   found;
  int                     idx;

  // Search starts one past the last winner and wraps, so the most recent
  // winner has the lowest priority next time.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= num_req_p; off++) begin
      idx = (int'(ptr_q) + off) % num_req_p;
      if (!found && reqs_i[id_width_lp'(idx)]) begin
        found  = 1'b1;
        winner = id_width_lp'(idx);
      end
    end
  end

  always_comb begin
    grants_o = '0;
    if (found) grants_o[winner] = 1'b1;
  end

  assign tag_o = winner;
  assign v_o   = found;

  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i && found) ptr_d = winner;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= id_width_lp'(num_req_p - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_me_burst_arbiter.sv
// Shares one BP burst client channel (header + data) among several burst
// masters. Headers are arbitrated round-robin; a master whose message carries
// data stays locked until its last beat is forwarded, so streams never mix.
//
// Ports:
//   clk_i, reset_n_i                  clock, synchronous active-low reset
//   mem_header_i/_v_i/_ready_o        per-master header channels (slice i = master i)
//   mem_data_i/_v_i/_ready_o          per-master data channels
//   mem_header_o/_v_o/_ready_i        client header channel
//   mem_data_o/_v_o/_ready_i          client data channel
//   grant_id_o                        arbitration winner (idle) or locked master (data)
//   busy_o                            high while forwarding a data burst
module bp_me_burst_arbiter
  import bp_me_burst_arbiter_pkg::*;
  #(parameter int num_req_p         = 2,
    parameter int data_width_p      = 64,
    parameter int cce_block_width_p = 512,
    parameter int payload_mask_p    = 0,
    localparam int header_width_lp  = $bits(bp_mem_header_s),
    localparam int id_width_lp      = $clog2(num_req_p))
  (input  logic                                  clk_i,
   input  logic                                  reset_n_i,

   input  logic [num_req_p*header_width_lp-1:0]  mem_header_i,
   input  logic [num_req_p-1:0]                  mem_header_v_i,
   output logic [num_req_p-1:0]                  mem_header_ready_o,
   input  logic [num_req_p*data_width_p-1:0]     mem_data_i,
   input  logic [num_req_p-1:0]                  mem_data_v_i,
   output logic [num_req_p-1:0]                  mem_data_ready_o,

   output logic [header_width_lp-1:0]            mem_header_o,
   output logic                                  mem_header_v_o,
   input  logic                                  mem_header_ready_i,
   output logic [data_width_p-1:0]               mem_data_o,
   output logic                                  mem_data_v_o,
   input  logic                                  mem_data_ready_i,

   output logic [id_width_lp-1:0]                grant_id_o,
   output logic                                  busy_o);

  localparam int beat_bytes_lp = data_width_p / 8;
  localparam int max_beats_lp  = cce_block_width_p / data_width_p;
  localparam int cnt_width_lp  = $clog2(max_beats_lp) + 1;

  localparam logic [15:0] payload_mask_lp = 16'(payload_mask_p);

  localparam logic [0:0] e_idle = 1'b0;
  localparam logic [0:0] e_data = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [id_width_lp-1:0]  lock_id_q, lock_id_d;
  logic [cnt_width_lp-1:0] beats_left_q, beats_left_d;

  logic [num_req_p-1:0]    arb_grants;
  logic [id_width_lp-1:0]  arb_tag;
  logic                    arb_v;
  logic [num_req_p-1:0]    lock_onehot;
  bp_mem_header_s          header_sel;
  logic [data_width_p-1:0] data_sel;
  logic                    in_idle, in_data;
  logic                    header_hs, data_hs;
  logic                    has_payload;
  logic [cnt_width_lp-1:0] nbeats;

  assign in_idle = (state_q == e_idle);
  assign in_data = (state_q == e_data);

  bp_me_burst_arbiter_rr #(.num_req_p(num_req_p)) rr_arb
    (.clk_i    (clk_i),
     .reset_i  (~reset_n_i),
     .reqs_i   (mem_header_v_i),
     .yumi_i   (header_hs),
     .grants_o (arb_grants),
     .tag_o    (arb_tag),
     .v_o      (arb_v));

  // One-hot muxes: header follows the live arbitration grant, data follows the lock.
  always_comb begin
    header_sel = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (arb_grants[i]) header_sel = header_sel | mem_header_i[i*header_width_lp +: header_width_lp];
    end
  end

  always_comb begin
    lock_onehot            = '0;
    lock_onehot[lock_id_q] = 1'b1;
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (lock_onehot[i]) data_sel = data_sel | mem_data_i[i*data_width_p +: data_width_p];
    end
  end

  // Valids depend only on state and master valids, never on client readys.
  assign mem_header_o       = header_sel;
  assign mem_header_v_o     = reset_n_i & in_idle & arb_v;
  assign mem_header_ready_o = {num_req_p{reset_n_i & in_idle & mem_header_ready_i}} & arb_grants;
  assign mem_data_o         = data_sel;
  assign mem_data_v_o       = reset_n_i & in_data & mem_data_v_i[lock_id_q];
  assign mem_data_ready_o   = {num_req_p{reset_n_i & in_data & mem_data_ready_i}} & lock_onehot;
  assign grant_id_o         = in_idle ? arb_tag : lock_id_q;
  assign busy_o             = reset_n_i & in_data;

  assign header_hs   = mem_header_v_o & mem_header_ready_i;
  assign data_hs     = mem_data_v_o & mem_data_ready_i;
  assign has_payload = payload_mask_lp[header_sel.msg_type];
  assign nbeats      = cnt_width_lp'(burst_beats(header_sel.size, beat_bytes_lp, max_beats_lp));

  // beats_left counts remaining beats after the current one, so the beat
  // accepted while it reads zero closes the burst.
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    beats_left_d = beats_left_q;
    case (state_q)
      e_idle: begin
        if (header_hs) begin
          lock_id_d = arb_tag;
          if (has_payload) begin
            state_d      = e_data;
            beats_left_d = nbeats - cnt_width_lp'(1);
          end
        end
      end
      e_data: begin
        if (data_hs) begin
          if (beats_left_q == '0) state_d = e_idle;
          else                    beats_left_d = beats_left_q - cnt_width_lp'(1);
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= e_idle;
      lock_id_q    <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule
